npu_result_readback: RTL and testbench

- Receiving end of the NPU output path: captures the byte stream the NPU drives on D_OUT and buffers it.
- Packs the bytes into 32-bit words so the CPU can read them back over the register interface. This is the counterpart of the image/weight write path that loads the RAMs.
- Sits between npu_top's D_OUT and the Avalon-side ready/answer registers.
- Provides capture-done status, a byte count and error flags.

---
 rtl/npu_result_readback.sv | 113 +++++++++++
 tb/tb_npu_result_readback.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/npu_result_readback.sv
// rtl/npu_result_readback.sv - captures the NPU result byte stream, packs it into 32-bit words for CPU readback
module npu_result_readback #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        d_in,
    input  logic              d_valid,
    input  logic              start,
    input  logic [ADDR_W:0]   expected_len,
    input  logic              rd_req,
    input  logic [ADDR_W-3:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [31:0]       ready
);
    localparam int WORDS = DEPTH / 4;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [31:0]       mem [WORDS];
    logic [1:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-2:0] words_written;
    logic [31:0]       pack;
    logic              drop;
    logic              len_err;

    logic [1:0]        lane;
    logic [31:0]       merged;
    logic [ADDR_W:0]   count_next;
    logic              take;
    logic              word_wr;

    // pack holds only the lower lanes of the current word, so higher lanes of a
    // final partial word are naturally zero
    always_comb begin
        lane       = count[1:0];
        merged     = pack | (32'(d_in) << {lane, 3'b000});
        count_next = count + 1'b1;
        take       = (state == S_CAPTURE) && d_valid && !start;
        word_wr    = take && ((lane == 2'd3) || (count_next == len));
    end

    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[count[ADDR_W-1:2]] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            len           <= '0;
            count         <= '0;
            words_written <= '0;
            pack          <= '0;
            drop          <= 1'b0;
            len_err       <= 1'b0;
        end else if (start) begin
            if (expected_len > DEPTH_L) begin
                len_err <= 1'b1;
                len     <= DEPTH_L;
            end else begin
                len     <= expected_len;
            end
            count         <= '0;
            words_written <= '0;
            pack          <= '0;
            drop          <= 1'b0;
            state         <= (expected_len == '0) ? S_DONE : S_CAPTURE;
        end else if (d_valid) begin
            if (take) begin
                pack  <= word_wr ? 32'd0 : merged;
                count <= count_next;
                if (word_wr) begin
                    words_written <= words_written + 1'b1;
                end
                if (count_next == len) begin
                    state <= S_DONE;
                end
            end else begin
                drop <= 1'b1;
            end
        end
    end

    // Registered read; a same-cycle write is not yet visible, giving pre-write data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= ({1'b0, rd_addr} < words_written) ? mem[rd_addr] : 32'd0;
            end
        end
    end

    always_comb begin
        ready                  = '0;
        ready[0]               = (state == S_DONE);
        ready[1]               = (state == S_CAPTURE);
        ready[2]               = drop;
        ready[3]               = len_err;
        ready[16+ADDR_W:16]    = count;
    end
endmodule

// File: tb/tb_npu_result_readback.sv
// tb/tb_npu_result_readback.sv - randomized self-checking bench for npu_result_readback
module tb_npu_result_readback;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        d_in;
    logic              d_valid;
    logic              start;
    logic [ADDR_W:0]   expected_len;
    logic              rd_req;
    logic [ADDR_W-3:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [31:0]       ready;

    always #5 clk = ~clk;

    npu_result_readback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .start(start),
        .expected_len(expected_len), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .ready(ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 capturing, 2 done
    int         m_state;
    int         m_len;
    int         m_count;
    bit         m_drop;
    bit         m_lenerr;
    logic [7:0] m_bytes [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_len = 0; m_count = 0; m_drop = 0; m_lenerr = 0;
    endtask

    function automatic logic [31:0] exp_ready();
        logic [31:0] r;
        logic [31:0] c;
        r = '0;
        c = m_count;
        r[16+ADDR_W:16] = c[ADDR_W:0];
        r[3] = m_lenerr;
        r[2] = m_drop;
        r[1] = (m_state == 1);
        r[0] = (m_state == 2);
        return r;
    endfunction

    // Words visible to the CPU: completed words, plus the padded tail once done
    function automatic logic [31:0] exp_word(input int a);
        logic [31:0] w;
        int ww;
        ww = (m_state == 2) ? (m_count + 3) / 4 : m_count / 4;
        w = '0;
        if (a < ww) begin
            for (int k = 0; k < 4; k++) begin
                if (4*a + k < m_count) w[8*k +: 8] = m_bytes[4*a + k];
            end
        end
        return w;
    endfunction

    task automatic cyc(input bit s, input int el, input bit v, input logic [7:0] d);
        start = s; expected_len = el[ADDR_W:0]; d_valid = v; d_in = d;
        @(posedge clk);
        if (s) begin
            if (el > DEPTH) m_lenerr = 1;
            m_len   = (el > DEPTH) ? DEPTH : el;
            m_count = 0;
            m_drop  = 0;
            m_state = (m_len == 0) ? 2 : 1;
        end else if (v) begin
            if (m_state == 1) begin
                m_bytes[m_count] = d;
                m_count++;
                if (m_count == m_len) m_state = 2;
            end else begin
                m_drop = 1;
            end
        end
        #1;
        start = 1'b0; d_valid = 1'b0;
        chk("ready", ready, exp_ready());
    endtask

    task automatic rd(input int a);
        logic [31:0] e;
        rd_req = 1'b1; rd_addr = a[ADDR_W-3:0];
        e = exp_word(a);
        @(posedge clk);
        #1;
        chk("rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("rd_data", rd_data, e);
    endtask

    task automatic rd_end();
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; d_in = '0; d_valid = 1'b0; start = 1'b0;
        expected_len = '0; rd_req = 1'b0; rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", ready, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        reset = 1'b1;

        // Eight consecutive bytes
        cyc(1, 8, 0, 8'h00);
        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 8'(i));
        chk("t1_done", ready, 32'h0008_0001);
        rd(0); chk("t1_w0", rd_data, 32'h04030201);
        rd(1); chk("t1_w1", rd_data, 32'h08070605);
        rd_end();

        // Six bytes with gaps, partial tail word
        cyc(1, 6, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 8'(8'hA0 + i));
            cyc(0, 0, 0, 8'h00);
        end
        rd(1); chk("t2_w1", rd_data, 32'h0000A5A4);
        rd(2); chk("t2_w2", rd_data, 32'h00000000);
        rd_end();
        chk("t2_nodrop", {31'd0, ready[2]}, 32'd0);

        // Stray byte in DONE, then restart clears flags
        cyc(0, 0, 1, 8'hFF);
        chk("t3_drop", ready, 32'h0006_0005);
        cyc(1, 4, 0, 8'h00);
        chk("t3_cleared", ready, 32'h0000_0002);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'($urandom));

        // Over-length request saturates at DEPTH
        cyc(1, DEPTH + 5, 0, 8'h00);
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 1, 8'($urandom));
        chk("t4_full", ready, 32'h0400_000D);
        rd(DEPTH/4 - 1);
        rd(0);
        rd_end();

        // Reset in the middle of a capture
        cyc(1, 8, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'($urandom));
        rd(0);
        reset = 1'b0;
        #1;
        model_reset();
        chk("t5_ready_rst", ready, 32'd0);
        chk("t5_rdv_rst", {31'd0, rd_valid}, 32'd0);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(0); chk("t5_w0", rd_data, 32'd0);
        rd_end();

        // start coincident with d_valid, then zero-length capture
        cyc(1, 8, 0, 8'h00);
        cyc(0, 0, 1, 8'h11);
        cyc(0, 0, 1, 8'h22);
        cyc(1, 5, 1, 8'h77);
        chk("t6_coincident", ready, 32'h0000_0002);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h30 + i));
        rd(0); rd(1); rd_end();
        cyc(1, 0, 0, 8'h00);
        chk("t6_zero_len", ready, 32'h0000_0001);
        rd(0); rd_end();

        // Randomized captures with gaps, restarts, strays and back-to-back reads
        for (int it = 0; it < 40; it++) begin
            int budget;
            cyc(1, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40), 0, 8'h00);
            budget = 0;
            while (m_state == 1 && budget < 300) begin
                if ($urandom_range(0, 30) == 0)
                    cyc(1, $urandom_range(1, 40), $urandom_range(0, 1), 8'($urandom));
                else
                    cyc(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom));
                budget++;
            end
            chk("rand_budget", {31'd0, (m_state == 1)}, 32'd0);
            if ($urandom_range(0, 2) == 0) cyc(0, 0, 1, 8'($urandom));
            for (int a = 0; a <= (m_count + 3) / 4 + 1; a++) rd(a);
            rd_end();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
